// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// Byte-stream loader that packs little-endian words into the instruction memory while holding the CPU in reset.
// Optional running XOR of written words is enabled with the INSTR_LOADER_CHECKSUM_EN macro.
module instr_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  input  logic [7:0]                    in_byte_i,
  input  logic                          in_last_i,
  output logic                          in_ready_o,
  output logic                          wr_en_o,
  output logic [ADDR_W-1:0]             wr_addr_o,
  output logic [31:0]                   wr_data_o,
  output logic                          hold_cpu_o,
  output logic                          done_o,
  output logic                          err_overflow_o,
  output logic                          err_partial_o,
  output logic [$clog2(MEM_SIZE/4):0]   words_written_o,
  output logic [31:0]                   checksum_o
);

  localparam int WCNT_W = $clog2(MEM_SIZE/4) + 1;
  localparam logic [ADDR_W-1:0] MEM_END = ADDR_W'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WCNT_W-1:0]   words_q, words_d;
  logic                last_q, last_d;
  logic                partial_q, partial_d;
  logic                restart;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      last_q     <= 1'b0;
      partial_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      last_q     <= last_d;
      partial_q  <= partial_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    buf_d          = buf_q;
    addr_d         = addr_q;
    words_d        = words_q;
    last_d         = last_q;
    partial_d      = partial_q;
    restart        = 1'b0;
    in_ready_o     = 1'b0;
    wr_en_o        = 1'b0;
    wr_addr_o      = '0;
    wr_data_o      = '0;
    hold_cpu_o     = 1'b0;
    done_o         = 1'b0;
    err_overflow_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        restart = start_i;
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        hold_cpu_o = 1'b1;
        if (in_valid_i) begin
          buf_d[{byte_cnt_q, 3'b000} +: 8] = in_byte_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (in_last_i) begin
            last_d = 1'b1;
            if (byte_cnt_q != 2'd3) begin
              partial_d = 1'b1;
            end
          end
          if (byte_cnt_q == 2'd3 || in_last_i) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wr_en_o    = 1'b1;
        wr_addr_o  = addr_q;
        wr_data_o  = buf_q;
        hold_cpu_o = 1'b1;
        words_d    = words_q + WCNT_W'(1);
        addr_d     = addr_q + ADDR_W'(4);
        byte_cnt_d = '0;
        buf_d      = '0;
        // The stream end takes priority, so a full memory ending on in_last is a clean finish.
        if (last_q) begin
          state_d = S_DONE;
        end else if (addr_q + ADDR_W'(4) == MEM_END) begin
          state_d = S_ERR;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        restart = start_i;
      end
      S_ERR: begin
        err_overflow_o = 1'b1;
        hold_cpu_o     = 1'b1;
        restart        = start_i;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      state_d    = S_LOAD;
      byte_cnt_d = '0;
      buf_d      = '0;
      addr_d     = '0;
      words_d    = '0;
      last_d     = 1'b0;
      partial_d  = 1'b0;
    end
  end

  assign err_partial_o   = partial_q;
  assign words_written_o = words_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_WRITE) begin
      csum_d = csum_q ^ buf_q;
    end else if (restart) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
// Self-checking bench for instr_loader: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_instr_loader;

  localparam int MEM_SIZE = 16;
  localparam int ADDR_W   = 64;
  localparam int WCNT_W   = $clog2(MEM_SIZE/4) + 1;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk_i;
  logic              reset_i;
  logic              start_i;
  logic              in_valid_i;
  logic [7:0]        in_byte_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              hold_cpu_o;
  logic              done_o;
  logic              err_overflow_o;
  logic              err_partial_o;
  logic [WCNT_W-1:0] words_written_o;
  logic [31:0]       checksum_o;

  instr_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .in_valid_i(in_valid_i),
    .in_byte_i(in_byte_i),
    .in_last_i(in_last_i),
    .in_ready_o(in_ready_o),
    .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .hold_cpu_o(hold_cpu_o),
    .done_o(done_o),
    .err_overflow_o(err_overflow_o),
    .err_partial_o(err_partial_o),
    .words_written_o(words_written_o),
    .checksum_o(checksum_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the loader seen as a byte queue that drains into word-sized writes.
  bit          modelValid = 1'b0;
  bit          active, finished, overflowed, writePending, sawLast, partial;
  int          wordIdx;
  logic [31:0] xorAcc;
  logic [7:0]  pending[$];

  function automatic logic [31:0] packWord();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < pending.size(); i++) w = w | (32'(pending[i]) << (8 * i));
    return w;
  endfunction

  function automatic bit modelReady();
    return active && !writePending && !overflowed;
  endfunction

  function automatic void modelClear();
    pending.delete();
    wordIdx      = 0;
    xorAcc       = 32'h0;
    partial      = 1'b0;
    sawLast      = 1'b0;
    overflowed   = 1'b0;
    writePending = 1'b0;
    finished     = 1'b0;
  endfunction

  // Advance the model on every rising edge using the inputs held stable across it.
  initial begin
    forever begin
      @(posedge clk_i);
      if (reset_i) begin
        modelClear();
        active     = 1'b0;
        modelValid = 1'b1;
      end else if (modelValid) begin
        if (writePending) begin
          xorAcc = xorAcc ^ packWord();
          wordIdx++;
          pending.delete();
          writePending = 1'b0;
          if (sawLast) begin
            finished = 1'b1;
            active   = 1'b0;
          end else if (wordIdx * 4 == MEM_SIZE) begin
            overflowed = 1'b1;
          end
        end else if (start_i && (!active || overflowed)) begin
          modelClear();
          active = 1'b1;
        end else if (modelReady() && in_valid_i) begin
          pending.push_back(in_byte_i);
          if (in_last_i) begin
            sawLast = 1'b1;
            if (pending.size() < 4) partial = 1'b1;
          end
          if (pending.size() == 4 || in_last_i) writePending = 1'b1;
        end
      end
    end
  end

  // Every falling edge after reset, all outputs must match what the model implies.
  initial begin
    forever begin
      @(negedge clk_i);
      if (modelValid) begin
        checkOutput("in_ready", in_ready_o, modelReady());
        checkOutput("wr_en", wr_en_o, writePending);
        checkOutput("wr_addr", wr_addr_o, writePending ? 64'(wordIdx * 4) : 64'd0);
        checkOutput("wr_data", wr_data_o, writePending ? packWord() : 32'h0);
        checkOutput("hold_cpu", hold_cpu_o, active);
        checkOutput("done", done_o, finished);
        checkOutput("err_overflow", err_overflow_o, overflowed);
        checkOutput("err_partial", err_partial_o, partial);
        checkOutput("words_written", words_written_o, 64'(wordIdx));
        checkOutput("checksum", checksum_o, CSUM_EN ? xorAcc : 32'h0);
      end
    end
  end

  // Capture every write for the directed scenarios' literal checks.
  logic [63:0] logAddr[$];
  logic [31:0] logData[$];
  initial begin
    forever begin
      @(negedge clk_i);
      if (wr_en_o === 1'b1) begin
        logAddr.push_back(wr_addr_o);
        logData.push_back(wr_data_o);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  task automatic pulseStart();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it, within a bounded number of cycles.
  task automatic applyStimulus(input logic [7:0] b, input logic last);
    logic acc = 1'b0;
    int   waited = 0;
    in_valid_i = 1'b1;
    in_byte_i  = b;
    in_last_i  = last;
    while (!acc && waited < 40) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i); #1;
      waited++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    checkOutput("handshake", acc, 1'b1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    checkOutput("done_reached", done_o, 1'b1);
  endtask

  task automatic checkWrite(input string name, input int idx, input logic [63:0] addr, input logic [31:0] data);
    if (logAddr.size() > idx) begin
      checkOutput({name, "_addr"}, logAddr[idx], addr);
      checkOutput({name, "_data"}, logData[idx], 64'(data));
    end else begin
      checkOutput({name, "_present"}, 64'(logAddr.size()), 64'(idx + 1));
    end
  endtask

  logic [7:0] streamBytes[16];
  int         accepted;

  initial begin
    reset_i    = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_byte_i  = 8'h0;
    in_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    checkOutput("reset_hold_cpu", hold_cpu_o, 1'b0);
    checkOutput("reset_in_ready", in_ready_o, 1'b0);
    checkOutput("reset_words", words_written_o, 64'd0);

    // Single word ending exactly on the 4th byte.
    clearLog();
    pulseStart();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h80, 1'b0);
    applyStimulus(8'hD2, 1'b1);
    checkOutput("t1_wren_latency", wr_en_o, 1'b1);
    checkOutput("t1_wr_data_now", wr_data_o, 32'hD2800000);
    waitDone();
    checkOutput("t1_write_count", 64'(logAddr.size()), 64'd1);
    checkWrite("t1_w0", 0, 64'd0, 32'hD2800000);
    checkOutput("t1_words", words_written_o, 64'd1);
    checkOutput("t1_hold_cpu", hold_cpu_o, 1'b0);

    // 12 random bytes with an idle cycle between each transfer.
    clearLog();
    pulseStart();
    for (int i = 0; i < 12; i++) begin
      streamBytes[i] = 8'($urandom);
      applyStimulus(streamBytes[i], i == 11);
      if (i % 4 == 3) checkOutput("t2_ready_in_write", in_ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    waitDone();
    checkOutput("t2_write_count", 64'(logAddr.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      checkWrite("t2_w", k, 64'(4 * k),
                 {streamBytes[4*k+3], streamBytes[4*k+2], streamBytes[4*k+1], streamBytes[4*k]});
    end
    checkOutput("t2_words", words_written_o, 64'd3);

    // Six bytes: the second word is zero-padded and flagged partial.
    clearLog();
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus(8'h11 + 8'(i), i == 5);
    waitDone();
    checkWrite("t3_w0", 0, 64'd0, 32'h14131211);
    checkWrite("t3_w1", 1, 64'd4, 32'h00001615);
    checkOutput("t3_partial", err_partial_o, 1'b1);
    checkOutput("t3_words", words_written_o, 64'd2);

    // Exactly filling memory with in_last on the final byte is a clean finish.
    clearLog();
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), i == 15);
    waitDone();
    checkOutput("t4_write_count", 64'(logAddr.size()), 64'd4);
    checkWrite("t4_w3", 3, 64'd12, 32'h2F2E2D2C);
    checkOutput("t4_no_overflow", err_overflow_o, 1'b0);

    // Same stream without in_last overflows and refuses a 17th byte.
    clearLog();
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t4_overflow", err_overflow_o, 1'b1);
    checkOutput("t4_err_hold", hold_cpu_o, 1'b1);
    accepted   = 0;
    in_valid_i = 1'b1;
    in_byte_i  = 8'h99;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (in_ready_o !== 1'b0) accepted++;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    checkOutput("t4_17th_refused", 64'(accepted), 64'd0);
    checkOutput("t4_no_5th_write", 64'(logAddr.size()), 64'd4);

    // Restart from the error state, then reset mid-word discards the partial word.
    clearLog();
    pulseStart();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    checkOutput("t5_wr_en", wr_en_o, 1'b0);
    checkOutput("t5_in_ready", in_ready_o, 1'b0);
    checkOutput("t5_hold_cpu", hold_cpu_o, 1'b0);
    checkOutput("t5_done", done_o, 1'b0);
    checkOutput("t5_wr_addr", wr_addr_o, 64'd0);
    checkOutput("t5_wr_data", wr_data_o, 32'h0);
    checkOutput("t5_checksum", checksum_o, 32'h0);
    checkOutput("t5_no_write", 64'(logAddr.size()), 64'd0);
    pulseStart();
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b0);
    applyStimulus(8'hDD, 1'b1);
    waitDone();
    checkWrite("t5_w0", 0, 64'd0, 32'hDDCCBBAA);

    // Checksum over two words.
    clearLog();
    pulseStart();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(8'h0F, i == 3);
    waitDone();
    checkOutput("t6_checksum", checksum_o, CSUM_EN ? 32'hF0F00F0F : 32'h0);

    // Random traffic: starts, gaps, early last, overflow and occasional resets.
    clearLog();
    for (int c = 0; c < 3000; c++) begin
      reset_i    = ($urandom_range(0, 199) == 0);
      start_i    = ($urandom_range(0, 15) == 0);
      in_valid_i = 1'($urandom_range(0, 1));
      in_byte_i  = 8'($urandom);
      in_last_i  = ($urandom_range(0, 7) == 0);
      @(posedge clk_i); #1;
    end
    reset_i    = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory. Accepts a byte stream from the host/testbench over a valid/ready handshake.
- Packs every 4 bytes into a 32-bit instruction (little-endian) and issues single-cycle writes to the writable instruction memory's write port at word-aligned byte addresses starting at 0.
- Holds the CPU in reset while loading. Reports done, overflow and partial-word status.

Parameters:
- MEM_SIZE, 1024, instruction memory size in bytes; power of two, > 4.
- ADDR_W, 64, width of the byte address driven to memory.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse to begin a load.
- in_valid  input  1  in_byte is valid this cycle.
- in_byte  input  8  stream byte.
- in_last  input  1  qualifies the final byte of the stream.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  write strobe to the instruction memory.
- wr_addr  output  ADDR_W  byte address; bits [1:0] are always 0.
- wr_data  output  32  instruction word.
- hold_cpu  output  1  keeps the CPU in reset.
- done  output  1  load completed.
- err_overflow  output  1  stream exceeded MEM_SIZE.
- err_partial  output  1  stream length was not a multiple of 4.
- words_written  output  $clog2(MEM_SIZE/4)+1  count of words written.
- checksum  output  32  XOR of all written words; see Optional Feature.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset (clk edge with reset=1, including mid-load):
  - State goes to IDLE; byte count and word buffer clear; word address = 0.
  - All outputs = 0, including wr_en; no write issues on the reset cycle.
  - A partially assembled word is discarded.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - in_ready=0, hold_cpu=0.
  - start=1 -> LOAD. Clears word address, byte count, words_written, checksum, done, err_*.
- LOAD:
  - in_ready=1, hold_cpu=1.
  - Handshake: a byte transfers when in_valid && in_ready on a clk edge.
  - A transferred byte goes into word lane byte_cnt (lane 0 = bits [7:0]); byte_cnt increments.
  - -> WRITE on the edge transferring the byte with byte_cnt==3, or any byte with in_last=1.
  - in_last on byte_cnt<3: unfilled upper lanes are zero; err_partial set.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_addr=current word address, wr_data=assembled word.
  - in_ready=0, hold_cpu=1.
  - Next edge: words_written++, address += 4, byte_cnt = 0, buffer cleared.
  - If the word contained the last byte -> DONE.
  - Else if the new address == MEM_SIZE -> ERR.
  - Else -> LOAD.
- Write latency: wr_en asserts on the cycle after the 4th byte's handshake edge.
- Throughput: 4 bytes per 5 cycles maximum.
- DONE:
  - done=1, hold_cpu=0, in_ready=0. Holds until reset or start.
  - start -> LOAD, with the same clears as from IDLE.
- ERR:
  - err_overflow=1, hold_cpu=1, in_ready=0. No further writes.
  - start -> LOAD, with the same clears as from IDLE. reset -> IDLE.
- Other rules:
  - start in LOAD or WRITE is ignored.
  - in_valid in IDLE, WRITE, DONE or ERR is not accepted and has no effect.
  - A zero-length stream is impossible: the first byte always carries data.
  - The full-memory boundary is exact: MEM_SIZE/4 words ending with in_last -> DONE, not ERR.
  - words_written saturates naturally at MEM_SIZE/4.
  - wr_addr never reaches MEM_SIZE.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - checksum = XOR of every wr_data written since the last start.
  - Updated on the edge ending WRITE; cleared by reset and start.
  - Valid when done=1.
- Undefined: checksum is tied to 32'h0 and no checksum register is synthesized.

Test Plan:
- Reset then start, stream bytes 8'h00,8'h00,8'h80,8'hD2 (last on 4th) -> wr_en one cycle after 4th handshake with wr_addr=0, wr_data=32'hD2800000; then done=1, words_written=1, hold_cpu=0.
- 12-byte stream with in_valid toggling every other cycle -> 3 writes at addresses 0, 4, 8; in_ready=0 during each WRITE cycle; no bytes lost.
- 6-byte stream 8'h11..8'h16, last on 6th -> writes 32'h14131211 @0 and 32'h00001615 @4; err_partial=1, done=1.
- MEM_SIZE=16: 16 bytes with last on 16th -> 4 writes (0..12), done=1, err_overflow=0. Same stream without last and a 17th byte offered -> ERR, err_overflow=1, in_ready=0, no 5th write.
- Reset asserted the cycle after the 3rd byte of a word -> no wr_en; all outputs 0. A new start plus 4 bytes writes to address 0.
- With INSTR_LOADER_CHECKSUM_EN: words 32'hFFFF0000, 32'h0F0F0F0F -> checksum=32'hF0F00F0F at done. Without the macro -> checksum=0.
